// File: rtl/sd_card_cmd_responder.sv
// Card-side SD CMD line endpoint: receives 48-bit host commands, reports them,
// then serialises the R1/R2/R3 response supplied by card logic.
module sd_card_cmd_responder #(
    parameter int NCR_CLKS     = 2,
    parameter int RESP_TIMEOUT = 65535
) (
    input  logic         ex_clk,
    input  logic         reset,
    input  logic         sd_clk,
    input  logic         sd_cmd_in,
    output logic         sd_cmd_out,
    output logic         sd_cmd_oe,
    output logic         cmd_valid,
    output logic [5:0]   cmd_index,
    output logic [31:0]  cmd_arg,
    output logic         cmd_err,
    output logic         resp_ready,
    input  logic         resp_valid,
    input  logic [1:0]   resp_type,
    input  logic [5:0]   resp_index,
    input  logic [126:0] resp_payload,
    output logic         busy
);
    typedef enum logic [2:0] {
        S_IDLE, S_RX, S_CHECK, S_WAIT_RESP, S_NCR, S_TX, S_DONE
    } state_t;

    localparam logic [6:0]  NCR_LAST = 7'(NCR_CLKS - 1);
    localparam logic [15:0] TO_LAST  = 16'(RESP_TIMEOUT - 1);

    state_t       state, state_nx;
    logic         sd_clk_q, rise, fall, xfer, crc_bad, in_crc_field, tx_bit;
    logic [47:0]  rx_sr;
    logic [6:0]   rx_crc, tx_crc;
    logic [135:0] tx_sr;
    logic         tx_r1;
    logic [7:0]   tx_last, bit_cnt;
    logic [6:0]   ncr_cnt;
    logic [15:0]  to_cnt;

    function automatic logic [6:0] crc7_step(input logic [6:0] crc, input logic b);
        logic fb;
        fb = b ^ crc[6];
        return {crc[5:0], 1'b0} ^ (fb ? 7'h09 : 7'h00);
    endfunction

    always_comb begin
        rise         = ~sd_clk_q & sd_clk;
        fall         = sd_clk_q & ~sd_clk;
        resp_ready   = (state == S_WAIT_RESP);
        busy         = (state != S_IDLE);
        xfer         = resp_valid & resp_ready;
        crc_bad      = (rx_crc != rx_sr[7:1]) | ~rx_sr[0];
        // R1 CRC bits come from the running CRC, not the shift register
        in_crc_field = tx_r1 && (bit_cnt >= 8'd40) && (bit_cnt <= 8'd46);
        tx_bit       = in_crc_field ? tx_crc[6] : tx_sr[135];
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:      if (rise && !sd_cmd_in) state_nx = S_RX;
            S_RX: if (rise) begin
                if (bit_cnt == 8'd1 && !sd_cmd_in) state_nx = S_IDLE;
                else if (bit_cnt == 8'd47)         state_nx = S_CHECK;
            end
            S_CHECK:     state_nx = crc_bad ? S_IDLE : S_WAIT_RESP;
            S_WAIT_RESP: begin
                if (xfer)
                    state_nx = (resp_type == 2'b00) ? S_IDLE : S_NCR;
                else if (RESP_TIMEOUT != 0 && to_cnt == TO_LAST)
                    state_nx = S_IDLE;
            end
            S_NCR:       if (fall && ncr_cnt == NCR_LAST) state_nx = S_TX;
            S_TX:        if (fall && bit_cnt == tx_last)  state_nx = S_DONE;
            S_DONE:      if (fall) state_nx = S_IDLE;
            default:     state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge ex_clk) begin
        if (reset) state <= S_IDLE;
        else       state <= state_nx;
    end

    always_ff @(posedge ex_clk) sd_clk_q <= sd_clk;

    always_ff @(posedge ex_clk) begin
        if (reset) begin
            sd_cmd_out <= 1'b1;
            sd_cmd_oe  <= 1'b0;
            cmd_valid  <= 1'b0;
            cmd_err    <= 1'b0;
            cmd_index  <= '0;
            cmd_arg    <= '0;
            rx_sr      <= '0;
            rx_crc     <= '0;
            tx_sr      <= '0;
            tx_crc     <= '0;
            tx_r1      <= 1'b0;
            tx_last    <= '0;
            bit_cnt    <= '0;
            ncr_cnt    <= '0;
            to_cnt     <= '0;
        end else begin
            cmd_valid <= 1'b0;
            case (state)
                S_IDLE: begin
                    bit_cnt <= '0;
                    ncr_cnt <= '0;
                    to_cnt  <= '0;
                    if (rise && !sd_cmd_in) begin
                        rx_sr   <= '0;
                        rx_crc  <= '0;
                        bit_cnt <= 8'd1;
                    end
                end
                S_RX: if (rise) begin
                    rx_sr <= {rx_sr[46:0], sd_cmd_in};
                    if (bit_cnt < 8'd40)  rx_crc  <= crc7_step(rx_crc, sd_cmd_in);
                    if (bit_cnt < 8'd136) bit_cnt <= bit_cnt + 8'd1;
                end
                S_CHECK: begin
                    cmd_valid <= 1'b1;
                    cmd_err   <= crc_bad;
                    cmd_index <= rx_sr[45:40];
                    cmd_arg   <= rx_sr[39:8];
                    to_cnt    <= '0;
                end
                S_WAIT_RESP: begin
                    if (xfer) begin
                        ncr_cnt <= '0;
                        tx_crc  <= '0;
                        tx_r1   <= (resp_type == 2'b01);
                        tx_last <= (resp_type == 2'b10) ? 8'd135 : 8'd47;
                        case (resp_type)
                            2'b01:   tx_sr <= {2'b00, resp_index, resp_payload[31:0], 8'h01, 88'd0};
                            2'b10:   tx_sr <= {2'b00, 6'h3F, resp_payload, 1'b1};
                            default: tx_sr <= {2'b00, 6'h3F, resp_payload[31:0], 8'hFF, 88'd0};
                        endcase
                    end else if (to_cnt != 16'hFFFF) begin
                        to_cnt <= to_cnt + 16'd1;
                    end
                end
                S_NCR: if (fall) begin
                    if (ncr_cnt == NCR_LAST) begin
                        sd_cmd_oe  <= 1'b1;
                        sd_cmd_out <= tx_sr[135];
                        tx_sr      <= {tx_sr[134:0], 1'b0};
                        tx_crc     <= crc7_step(tx_crc, tx_sr[135]);
                        bit_cnt    <= 8'd1;
                    end else if (ncr_cnt != 7'h7F) begin
                        ncr_cnt <= ncr_cnt + 7'd1;
                    end
                end
                S_TX: if (fall) begin
                    sd_cmd_out <= tx_bit;
                    tx_sr      <= {tx_sr[134:0], 1'b0};
                    if (in_crc_field)         tx_crc <= {tx_crc[5:0], 1'b0};
                    else if (bit_cnt < 8'd40) tx_crc <= crc7_step(tx_crc, tx_sr[135]);
                    if (bit_cnt < 8'd136) bit_cnt <= bit_cnt + 8'd1;
                end
                S_DONE: if (fall) begin
                    sd_cmd_oe  <= 1'b0;
                    sd_cmd_out <= 1'b1;
                    bit_cnt    <= '0;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_sd_card_cmd_responder.sv
// Scoreboard bench: host driver issues commands, card model answers, and
// independent monitors check reported commands and frames seen on the CMD line.
module tb_sd_card_cmd_responder;
    localparam int NCR  = 2;
    localparam int TO   = 10;
    localparam int HALF = 8;

    typedef struct { logic [5:0] idx; logic [31:0] arg; logic err; } cmd_exp_t;
    typedef struct { logic give; logic [1:0] rtype; logic [5:0] idx; logic [126:0] pay; } card_t;
    typedef struct { logic [135:0] bits; int len; } frame_t;

    logic         ex_clk, reset, sd_clk, sd_cmd_in, sd_cmd_out, sd_cmd_oe;
    logic         cmd_valid, cmd_err, resp_ready, resp_valid, busy;
    logic [5:0]   cmd_index, resp_index;
    logic [31:0]  cmd_arg;
    logic [1:0]   resp_type;
    logic [126:0] resp_payload;

    int tests = 0, fails = 0;
    int div = 0, fall_total = 0, end_fall_mark = 0;
    int rr_rises = 0, last_rr_run = 0;
    cmd_exp_t exp_cmd[$];
    card_t    card_q[$];
    frame_t   exp_frame[$];

    sd_card_cmd_responder #(.NCR_CLKS(NCR), .RESP_TIMEOUT(TO)) dut (
        .ex_clk(ex_clk), .reset(reset), .sd_clk(sd_clk), .sd_cmd_in(sd_cmd_in),
        .sd_cmd_out(sd_cmd_out), .sd_cmd_oe(sd_cmd_oe), .cmd_valid(cmd_valid),
        .cmd_index(cmd_index), .cmd_arg(cmd_arg), .cmd_err(cmd_err),
        .resp_ready(resp_ready), .resp_valid(resp_valid), .resp_type(resp_type),
        .resp_index(resp_index), .resp_payload(resp_payload), .busy(busy)
    );

    initial ex_clk = 1'b0;
    always #5 ex_clk = ~ex_clk;

    initial sd_clk = 1'b0;
    always @(negedge ex_clk) begin
        if (div == HALF - 1) begin
            div    <= 0;
            sd_clk <= ~sd_clk;
        end else begin
            div <= div + 1;
        end
    end

    always @(negedge sd_clk) fall_total <= fall_total + 1;

    task automatic chk(input string name, input logic [135:0] act, input logic [135:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic bad(input string name);
        tests++;
        fails++;
        $display("FAIL %s: event not expected", name);
    endtask

    task automatic exp_c(input logic [5:0] i, input logic [31:0] a, input logic e);
        cmd_exp_t c;
        c.idx = i; c.arg = a; c.err = e;
        exp_cmd.push_back(c);
    endtask

    task automatic card(input logic g, input logic [1:0] t, input logic [5:0] i, input logic [126:0] p);
        card_t c;
        c.give = g; c.rtype = t; c.idx = i; c.pay = p;
        card_q.push_back(c);
    endtask

    task automatic exp_f(input logic [135:0] b, input int len);
        frame_t f;
        f.bits = b; f.len = len;
        exp_frame.push_back(f);
    endtask

    // Host side: drive on sd_clk falls so the card samples on rises
    task automatic send_cmd(input logic [47:0] f);
        for (int i = 47; i >= 0; i--) begin
            @(negedge sd_clk);
            sd_cmd_in = f[i];
        end
        @(posedge sd_clk);
        end_fall_mark = fall_total;
        @(negedge sd_clk);
        sd_cmd_in = 1'b1;
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while (busy && n < 6000) begin
            @(posedge ex_clk); #1;
            n++;
        end
        chk(name, busy, 1'b0);
        repeat (4) @(posedge ex_clk);
        #1;
    endtask

    // Card logic model: answers each good command from card_q
    initial begin : card_model
        card_t d;
        resp_valid = 1'b0; resp_type = 2'b00; resp_index = '0; resp_payload = '0;
        forever begin
            @(posedge ex_clk); #1;
            if (cmd_valid && !cmd_err && card_q.size() > 0) begin
                d = card_q.pop_front();
                if (d.give) begin
                    resp_type = d.rtype; resp_index = d.idx; resp_payload = d.pay;
                    resp_valid = 1'b1;
                    @(posedge ex_clk); #1;
                    resp_valid = 1'b0;
                end
            end
        end
    end

    initial begin : cmd_mon
        cmd_exp_t e;
        logic cv_p;
        cv_p = 1'b0;
        forever begin
            @(posedge ex_clk); #1;
            if (cmd_valid) begin
                chk("cmd_valid_width", cv_p, 1'b0);
                if (exp_cmd.size() == 0) bad("unexpected_cmd_valid");
                else begin
                    e = exp_cmd.pop_front();
                    chk("cmd_index", cmd_index, e.idx);
                    chk("cmd_arg", cmd_arg, e.arg);
                    chk("cmd_err", cmd_err, e.err);
                end
            end
            cv_p = cmd_valid;
        end
    end

    // Line monitor acts as the host receiver: samples on sd_clk rises while oe=1
    initial begin : line_mon
        logic oe_p, sc_p, rr_p;
        logic [135:0] bits;
        int nb, oe_cyc, rr_run;
        frame_t f;
        oe_p = 1'b0; sc_p = 1'b0; rr_p = 1'b0; bits = '0; nb = 0; oe_cyc = 0; rr_run = 0;
        forever begin
            @(posedge ex_clk); #1;
            if (sd_cmd_oe && !oe_p) begin
                bits = '0; nb = 0; oe_cyc = 0;
                chk("ncr_falls", 136'(fall_total - end_fall_mark), 136'(NCR));
            end
            if (sd_cmd_oe) oe_cyc++;
            if (sd_cmd_oe && sd_clk && !sc_p) begin
                bits = {bits[134:0], sd_cmd_out};
                nb++;
            end
            if (!sd_cmd_oe && oe_p && !reset) begin
                if (exp_frame.size() == 0) bad("unexpected_frame");
                else begin
                    f = exp_frame.pop_front();
                    chk("frame_bits", bits, f.bits);
                    chk("frame_len", 136'(nb), 136'(f.len));
                    chk("oe_cycles", 136'(oe_cyc), 136'(f.len * 2 * HALF));
                end
            end
            if (resp_ready) rr_run++;
            else if (rr_p) begin
                last_rr_run = rr_run;
                rr_run = 0;
            end
            if (resp_ready && !rr_p) rr_rises++;
            oe_p = sd_cmd_oe; sc_p = sd_clk; rr_p = resp_ready;
        end
    end

    initial begin : main
        logic [126:0] pay2;
        int rr_save, n;
        reset = 1'b1;
        sd_cmd_in = 1'b1;
        pay2 = {127{1'b1}} ^ 127'd1;
        repeat (5) @(posedge ex_clk);
        #1;
        chk("rst_out", sd_cmd_out, 1'b1);
        chk("rst_oe", sd_cmd_oe, 1'b0);
        chk("rst_valid", cmd_valid, 1'b0);
        chk("rst_err", cmd_err, 1'b0);
        chk("rst_index", cmd_index, 6'd0);
        chk("rst_arg", cmd_arg, 32'd0);
        chk("rst_ready", resp_ready, 1'b0);
        chk("rst_busy", busy, 1'b0);
        @(negedge ex_clk) reset = 1'b0;

        // CMD0, no response
        exp_c(6'd0, 32'd0, 1'b0);
        card(1'b1, 2'b00, 6'd0, '0);
        send_cmd(48'h40_0000_0000_95);
        wait_idle("cmd0_busy");

        // CMD17 -> R1 idx 17, status 0x900
        exp_c(6'd17, 32'd0, 1'b0);
        card(1'b1, 2'b01, 6'd17, 127'h900);
        exp_f(136'h11_0000_0900_67, 48);
        send_cmd(48'h51_0000_0000_55);
        wait_idle("r1_busy");

        // CMD8 with corrupted CRC: reported with error, no response
        rr_save = rr_rises;
        exp_c(6'd8, 32'h1AA, 1'b1);
        send_cmd(48'h48_0000_01AA_85);
        wait_idle("crc_err_busy");
        chk("crc_err_no_ready", 136'(rr_rises), 136'(rr_save));

        // CMD0 with end bit 0
        rr_save = rr_rises;
        exp_c(6'd0, 32'd0, 1'b1);
        send_cmd(48'h40_0000_0000_94);
        wait_idle("endbit_busy");
        chk("endbit_no_ready", 136'(rr_rises), 136'(rr_save));

        // CMD8 -> R3 with OCR
        exp_c(6'd8, 32'h1AA, 1'b0);
        card(1'b1, 2'b11, 6'd0, 127'h80FF8000);
        exp_f(136'h3F_80FF_8000_FF, 48);
        send_cmd(48'h48_0000_01AA_87);
        wait_idle("r3_busy");

        // CMD0 -> R2, 136 bits
        exp_c(6'd0, 32'd0, 1'b0);
        card(1'b1, 2'b10, 6'd0, pay2);
        exp_f({8'h3F, pay2, 1'b1}, 136);
        send_cmd(48'h40_0000_0000_95);
        wait_idle("r2_busy");

        // Transmission bit 0: a card response on the line, must be dropped
        send_cmd(48'h3F_FFFF_FFFF_FF);
        wait_idle("tbit0_busy");

        // No descriptor offered: abandon after TO cycles
        exp_c(6'd0, 32'd0, 1'b0);
        card(1'b0, 2'b00, 6'd0, '0);
        send_cmd(48'h40_0000_0000_95);
        wait_idle("timeout_busy");
        chk("timeout_cycles", 136'(last_rr_run), 136'(TO));

        // Reset while driving bit 20 of an R1
        exp_c(6'd17, 32'd0, 1'b0);
        card(1'b1, 2'b01, 6'd17, 127'h900);
        send_cmd(48'h51_0000_0000_55);
        n = 0;
        while (!sd_cmd_oe && n < 2000) begin
            @(posedge ex_clk); #1;
            n++;
        end
        chk("oe_before_reset", sd_cmd_oe, 1'b1);
        repeat (20) @(negedge sd_clk);
        @(negedge ex_clk) reset = 1'b1;
        @(posedge ex_clk); #1;
        chk("midrst_oe", sd_cmd_oe, 1'b0);
        chk("midrst_out", sd_cmd_out, 1'b1);
        chk("midrst_busy", busy, 1'b0);
        repeat (2) @(posedge ex_clk);
        @(negedge ex_clk) reset = 1'b0;

        exp_c(6'd0, 32'd0, 1'b0);
        card(1'b1, 2'b00, 6'd0, '0);
        send_cmd(48'h40_0000_0000_95);
        wait_idle("post_rst_busy");

        repeat (40) @(posedge ex_clk);
        #1;
        chk("cmd_q_drained", 136'(exp_cmd.size()), 136'd0);
        chk("frame_q_drained", 136'(exp_frame.size()), 136'd0);
        chk("card_q_drained", 136'(card_q.size()), 136'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/sd_card_cmd_responder.md
Name: sd_card_cmd_responder

Overview:
Card-side endpoint of the SD CMD line; the responder to the host's command sender and receiver. It deserialises 48-bit host command tokens, checks them, and presents index and argument to card logic. It then serialises the R1, R2 or R3 response that card logic supplies. It is used as the SD card model in host-controller benches and as the CMD front end of a card emulator, all on the ex_clk domain.

Parameters:
NCR_CLKS, 2, sd_clk periods of line-idle between command end bit and response start bit (legal 2..64)
RESP_TIMEOUT, 65535, ex_clk cycles to wait for resp_valid before abandoning the response (0 = never)

Ports:
ex_clk  input  1  system clock; the only clock in the block
reset  input  1  synchronous, active-high reset
sd_clk  input  1  SD clock level, sampled as data; edges detected internally
sd_cmd_in  input  1  CMD line as seen by the card
sd_cmd_out  output  1  CMD value driven by the card
sd_cmd_oe  output  1  1 = card drives CMD
cmd_valid  output  1  one-cycle pulse: a command frame has been captured
cmd_index  output  6  command index; valid while cmd_valid=1, held until the next frame
cmd_arg  output  32  command argument; same validity as cmd_index
cmd_err  output  1  qualifies cmd_valid: CRC7 mismatch or end bit = 0
resp_ready  output  1  responder is waiting for a response descriptor
resp_valid  input  1  response descriptor is valid
resp_type  input  2  00 none, 01 R1, 10 R2, 11 R3
resp_index  input  6  R1 index field
resp_payload  input  127  R1/R3: bits [31:0] are status/OCR; R2: bits [126:0] are CID/CSD[127:1], sent verbatim
busy  output  1  state is not IDLE

Behaviour:
- Edge detect: sd_clk_q is the registered sd_clk. rise = ~sd_clk_q & sd_clk; fall = sd_clk_q & ~sd_clk.
- Sampling and driving: sd_cmd_in is sampled only on rise cycles. sd_cmd_out and sd_cmd_oe change only on fall cycles, except on reset and except oe release in DONE.
- Reset values: sd_cmd_out=1, sd_cmd_oe=0, cmd_valid=0, cmd_err=0, cmd_index=0, cmd_arg=0, resp_ready=0, busy=0, state=IDLE, all counters 0.
- IDLE: on a rise with sd_cmd_in=0, go to RX with bit count 1. The shift register starts with that 0.
- RX: shift one bit per rise, MSB first, until 48 bits are held.
  - Bit 46 (transmission bit) must be 1. If it is 0, the frame is a card response seen on the line: return to IDLE with no cmd_valid.
- CHECK (one ex_clk cycle after the 48th bit):
  - CRC7 (x^7+x^3+1, init 0) is computed serially over bits 47..8 and compared with bits 7..1.
  - cmd_err = CRC mismatch OR bit0 = 0.
  - cmd_valid pulses for exactly 1 cycle; cmd_index = bits 45..40, cmd_arg = bits 39..8.
  - If cmd_err, go to IDLE and send no response. Otherwise go to WAIT_RESP.
- WAIT_RESP: resp_ready=1. A transfer occurs on a cycle with resp_valid & resp_ready.
  - The descriptor is captured into the TX shift register; resp_ready deasserts the next cycle.
  - resp_type 00 -> IDLE.
  - Any other type -> NCR.
  - After RESP_TIMEOUT cycles with no transfer -> IDLE.
  - Host activity on CMD is ignored in this state.
- Frame contents, MSB first:
  - R1 (48 bits): 0, 0, resp_index, payload[31:0], CRC7 over the preceding 40 bits, 1.
  - R3 (48 bits): 0, 0, 111111, payload[31:0], 1111111, 1.
  - R2 (136 bits): 0, 0, 111111, payload[126:0], 1.
- NCR: count NCR_CLKS falls with oe=0 and out=1. The fall that completes the count drives the start bit (oe=1) and enters TX.
- TX: each subsequent fall drives the next bit. The response CRC7 is computed on the fly.
- DONE: the end bit is held one full sd_clk period. The next fall sets oe=0 and out=1, then the block goes to IDLE. The host's first rise after release may already be a new start bit.
- No CMD sampling occurs in NCR, TX or DONE.
- Counters: bit count is 8 bits and saturates at 136; the NCR counter is 7 bits; the timeout counter is 16 bits. There is no wrap in any state.
- Reset mid-frame: state returns to IDLE and oe=0 on the next ex_clk edge. A partial command is discarded and never reported.
- If sd_clk stops mid-frame, the state is held indefinitely (no timeout in RX/NCR/TX).

Test Plan:
- CMD0 with arg 0 (0x40 00000000 95) -> cmd_valid one cycle, index 0, arg 0, cmd_err=0. Then resp_type=00 -> busy falls; oe stays 0 throughout.
- CMD17 with arg 0 (0x51 00000000 55), then R1 with index 17 and status 0x00000900, NCR_CLKS=2:
  - first driven bit appears on the 2nd fall after the command end bit;
  - line carries 0x11 00000900 0x67 (CRC 0x33), end 1;
  - oe drops exactly one sd_clk period after the end bit.
- CMD8 with arg 0x1AA sent with CRC byte 0x85 instead of 0x87 -> cmd_valid=1, cmd_err=1, no response; resp_ready never asserts.
- R3 with OCR 0x80FF8000 -> 48 bits on the line: 0x3F 80FF8000 FF. R2 with payload = {127{1'b1}} ^ 1 -> 136 bits, start 00, then 111111, payload, end 1; count verified.
- Frame with transmission bit 0 -> no cmd_valid, back to IDLE. In WAIT_RESP with RESP_TIMEOUT=10 and resp_valid=0 -> IDLE after 10 cycles.
- Reset asserted during TX bit 20 -> next cycle oe=0, out=1, busy=0. The next valid CMD0 is decoded correctly.
